// File: rtl/alu_operand_collector_if.sv
// alu_operand_collector_if: driver-side request bus and ALU-core issue handshake
interface alu_operand_collector_if #(parameter int WIDTH = 8, parameter int CWIDTH = 4);
  logic              ce;
  logic [1:0]        inp_valid;
  logic              mode;
  logic              cin;
  logic [CWIDTH-1:0] cmd;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic              out_ready;
  logic              out_valid;
  logic              out_mode;
  logic              out_cin;
  logic [CWIDTH-1:0] out_cmd;
  logic [WIDTH-1:0]  out_opa;
  logic [WIDTH-1:0]  out_opb;
  logic              err;
  logic              cmd_err;
  logic              busy;
  modport master (output ce, inp_valid, mode, cin, cmd, opa, opb, out_ready,
                  input out_valid, out_mode, out_cin, out_cmd, out_opa, out_opb, err, cmd_err, busy);
  modport slave  (input ce, inp_valid, mode, cin, cmd, opa, opb, out_ready,
                  output out_valid, out_mode, out_cin, out_cmd, out_opa, out_opb, err, cmd_err, busy);
endinterface

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: gathers split operands, validates CMD, issues one registered ALU op
module alu_operand_collector #(
  parameter int WIDTH   = 8,
  parameter int CWIDTH  = 4,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  alu_operand_collector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
  state_t     state;
  logic [7:0] cnt;
  logic       need_b;
  logic       legal;
  logic       two_op;
  always_comb begin
    legal  = bus.mode ? int'(bus.cmd) <= 10 : int'(bus.cmd) <= 13;
    two_op = bus.mode ? int'(bus.cmd) inside {0, 1, 2, 3, 8, 9, 10}
                      : int'(bus.cmd) inside {0, 1, 2, 3, 4, 5, 12, 13};
  end
  assign bus.busy      = state != IDLE;
  assign bus.out_valid = state == ISSUE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      need_b      <= 1'b0;
      bus.out_mode <= 1'b0;
      bus.out_cin <= 1'b0;
      bus.out_cmd <= '0;
      bus.out_opa <= '0;
      bus.out_opb <= '0;
      bus.err     <= 1'b0;
      bus.cmd_err <= 1'b0;
    end else begin
      // error pulses self-clear even while the clock enable is low
      bus.err     <= 1'b0;
      bus.cmd_err <= 1'b0;
      if (bus.ce) begin
        case (state)
          IDLE: if (|bus.inp_valid) begin
            if (!legal) bus.cmd_err <= 1'b1;
            else begin
              bus.out_mode <= bus.mode;
              bus.out_cin <= bus.cin;
              bus.out_cmd <= bus.cmd;
              bus.out_opa <= bus.inp_valid[0] ? bus.opa : '0;
              bus.out_opb <= bus.inp_valid[1] ? bus.opb : '0;
              if (two_op && bus.inp_valid != 2'b11) begin
                state  <= WAIT;
                cnt    <= 8'd1;
                need_b <= bus.inp_valid[0];
              end else state <= ISSUE;
            end
          end
          WAIT: if (need_b ? bus.inp_valid[1] : bus.inp_valid[0]) begin
            if (need_b) bus.out_opb <= bus.opb;
            else bus.out_opa <= bus.opa;
            state <= ISSUE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            bus.err <= 1'b1;
            state   <= IDLE;
          end else cnt <= cnt + 8'd1;
          ISSUE: if (bus.out_ready) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_operand_collector.sv
// tb_alu_operand_collector: table-driven vectors plus directed wait/timeout/reset sequences
module tb_alu_operand_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_operand_collector_if #(.WIDTH(8), .CWIDTH(4)) b ();
  alu_operand_collector_if #(.WIDTH(8), .CWIDTH(4)) b4 ();

  alu_operand_collector #(.WIDTH(8), .CWIDTH(4), .TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  alu_operand_collector #(.WIDTH(8), .CWIDTH(4), .TIMEOUT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  assign b4.ce        = b.ce;
  assign b4.inp_valid = b.inp_valid;
  assign b4.mode      = b.mode;
  assign b4.cin       = b.cin;
  assign b4.cmd       = b.cmd;
  assign b4.opa       = b.opa;
  assign b4.opb       = b.opb;
  assign b4.out_ready = b.out_ready;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0] v;
    logic       m;
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] bb;
    logic       ev;
    logic       ece;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic m, input logic c, input logic [3:0] cm,
                       input logic [7:0] a, input logic [7:0] bb);
    b.inp_valid = v;
    b.mode = m;
    b.cin = c;
    b.cmd = cm;
    b.opa = a;
    b.opb = bb;
  endtask

  task automatic idle_in;
    drive(2'b00, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    b.ce = 1'b1;
    b.out_ready = 1'b0;
    idle_in;
    tbl[0] = '{2'b11, 1'b1, 4'd0,  8'h12, 8'h34, 1'b1, 1'b0, 8'h12, 8'h34};
    tbl[1] = '{2'b11, 1'b1, 4'd12, 8'h11, 8'h22, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[2] = '{2'b01, 1'b1, 4'd4,  8'h07, 8'hff, 1'b1, 1'b0, 8'h07, 8'h00};
    tbl[3] = '{2'b10, 1'b0, 4'd6,  8'haa, 8'h3c, 1'b1, 1'b0, 8'h00, 8'h3c};
    tbl[4] = '{2'b01, 1'b0, 4'd14, 8'h01, 8'h02, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[5] = '{2'b11, 1'b0, 4'd13, 8'hf0, 8'h0f, 1'b1, 1'b0, 8'hf0, 8'h0f};
    tbl[6] = '{2'b10, 1'b1, 4'd11, 8'h01, 8'h02, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[7] = '{2'b01, 1'b1, 4'd5,  8'h55, 8'h66, 1'b1, 1'b0, 8'h55, 8'h00};

    #2 rst_n = 1'b0;
    #2;
    chk("rst valid", b.out_valid, 0);
    chk("rst busy", b.busy, 0);
    chk("rst opa", b.out_opa, 0);
    chk("rst err", b.err, 0);
    chk("rst cmd_err", b.cmd_err, 0);
    tick;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].m, 1'b0, tbl[i].cmd, tbl[i].a, tbl[i].bb);
      tick;
      idle_in;
      chk($sformatf("vec%0d valid", i), b.out_valid, tbl[i].ev);
      chk($sformatf("vec%0d cmd_err", i), b.cmd_err, tbl[i].ece);
      chk($sformatf("vec%0d busy", i), b.busy, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d opa", i), b.out_opa, tbl[i].ea);
        chk($sformatf("vec%0d opb", i), b.out_opb, tbl[i].eb);
        chk($sformatf("vec%0d cmd", i), b.out_cmd, tbl[i].cmd);
      end
      b.out_ready = 1'b1;
      tick;
      b.out_ready = 1'b0;
      chk($sformatf("vec%0d after valid", i), b.out_valid, 0);
      chk($sformatf("vec%0d after cmd_err", i), b.cmd_err, 0);
    end

    drive(2'b11, 1'b1, 1'b1, 4'd0, 8'h12, 8'h34);
    tick;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 1'b0, 1'b0, 4'd2, 8'hff, 8'hee);
      chk("hold valid", b.out_valid, 1);
      chk("hold opa", b.out_opa, 8'h12);
      chk("hold opb", b.out_opb, 8'h34);
      chk("hold cin", b.out_cin, 1);
      tick;
    end
    idle_in;
    chk("hold end opa", b.out_opa, 8'h12);
    b.out_ready = 1'b1;
    tick;
    b.out_ready = 1'b0;
    chk("hs valid", b.out_valid, 0);
    chk("hs busy", b.busy, 0);

    drive(2'b01, 1'b0, 1'b0, 4'd12, 8'ha5, 8'h00);
    tick;
    idle_in;
    chk("wait busy", b.busy, 1);
    for (int k = 2; k <= 15; k++) begin
      tick;
      chk("wait err", b.err, 0);
      chk("wait valid", b.out_valid, 0);
    end
    drive(2'b10, 1'b1, 1'b1, 4'd3, 8'hee, 8'h0f);
    tick;
    idle_in;
    chk("late valid", b.out_valid, 1);
    chk("late opa", b.out_opa, 8'ha5);
    chk("late opb", b.out_opb, 8'h0f);
    chk("late cmd", b.out_cmd, 12);
    chk("late mode", b.out_mode, 0);
    chk("late err", b.err, 0);
    b.out_ready = 1'b1;
    tick;
    b.out_ready = 1'b0;

    do_reset;
    drive(2'b10, 1'b1, 1'b0, 4'd8, 8'h00, 8'h77);
    tick;
    idle_in;
    for (int k = 1; k <= 18; k++) begin
      chk($sformatf("to16 err k=%0d", k), b.err, k == 16);
      chk($sformatf("to16 busy k=%0d", k), b.busy, k < 16);
      chk($sformatf("to4 err k=%0d", k), b4.err, k == 4);
      chk("err excl", b.err & b.cmd_err, 0);
      tick;
    end

    do_reset;
    drive(2'b10, 1'b1, 1'b0, 4'd8, 8'h00, 8'h77);
    tick;
    idle_in;
    for (int k = 1; k <= 23; k++) begin
      chk($sformatf("ce err k=%0d", k), b.err, k == 21);
      chk($sformatf("ce busy k=%0d", k), b.busy, k < 21);
      b.ce = !(k >= 3 && k <= 7);
      tick;
    end
    b.ce = 1'b1;

    drive(2'b01, 1'b1, 1'b0, 4'd0, 8'h99, 8'h00);
    tick;
    idle_in;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("rstw busy", b.busy, 0);
    chk("rstw opa", b.out_opa, 0);
    chk("rstw valid", b.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 4'd1, 8'h03, 8'h04);
    tick;
    idle_in;
    chk("fresh valid", b.out_valid, 1);
    chk("fresh opa", b.out_opa, 8'h03);
    chk("fresh opb", b.out_opb, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("rsti valid", b.out_valid, 0);
    chk("rsti opa", b.out_opa, 0);
    chk("rsti opb", b.out_opb, 0);
    chk("rsti cmd", b.out_cmd, 0);
    chk("rsti busy", b.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b10, 1'b0, 1'b0, 4'd7, 8'hff, 8'h5a);
    tick;
    idle_in;
    chk("post valid", b.out_valid, 1);
    chk("post opa", b.out_opa, 8'h00);
    chk("post opb", b.out_opb, 8'h5a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Front-end staging block between the ALU driver-side bus and the ALU datapath.
- Collects OPA/OPB, which may arrive on different cycles as flagged by INP_VALID.
- Validates CMD against MODE and enforces a parametrised operand-wait timeout.
- Presents one complete, registered operation to the ALU core through a valid/ready handshake.

Parameters:
- WIDTH, 8: operand width in bits.
- CWIDTH, 4: command width in bits.
- TIMEOUT, 16: number of cycles after the first operand by which the second must arrive. Legal range 2..255.

Ports:
- CLK, input, 1: clock, rising edge.
- RST, input, 1: asynchronous, active-low reset.
- CE, input, 1: clock enable. When low, the FSM, counter and outputs hold.
- INP_VALID, input, 2: bit0 = OPA valid, bit1 = OPB valid.
- MODE, input, 1: 1 = arithmetic, 0 = logical.
- CIN, input, 1: carry in.
- CMD, input, CWIDTH: operation code.
- OPA, input, WIDTH: operand A.
- OPB, input, WIDTH: operand B.
- OUT_READY, input, 1: ALU core accepts the issued operation.
- OUT_VALID, output, 1: issued operation valid.
- OUT_MODE, output, 1: registered MODE.
- OUT_CIN, output, 1: registered CIN.
- OUT_CMD, output, CWIDTH: registered CMD.
- OUT_OPA, output, WIDTH: registered OPA.
- OUT_OPB, output, WIDTH: registered OPB.
- ERR, output, 1: one-cycle pulse on operand-wait timeout.
- CMD_ERR, output, 1: one-cycle pulse on an illegal CMD for the current MODE.
- BUSY, output, 1: high in WAIT or ISSUE; inputs are ignored while high.

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM goes to IDLE and the counter clears to 0.
  - All outputs go to 0.
  - Applies mid-operation: partial operands and a pending issue are discarded.
- Command legality:
  - MODE=1: CMD 0..10 legal.
  - MODE=0: CMD 0..13 legal.
  - Everything else is illegal.
- Two-operand commands:
  - MODE=1: {0,1,2,3,8,9,10}.
  - MODE=0: {0,1,2,3,4,5,12,13}.
  - All other legal commands are single-operand.
- IDLE state (BUSY=0). Acts only when CE=1 and INP_VALID!=0:
  - Illegal CMD: CMD_ERR=1 for the next cycle; remain in IDLE; nothing is captured.
  - INP_VALID=11, or a single-operand command: capture MODE, CIN, CMD, and every flagged operand (unflagged operand registers to 0); go to ISSUE. OUT_VALID is high the next cycle (1-cycle latency).
  - Two-operand command with INP_VALID=01 or 10: capture MODE, CIN, CMD and the flagged operand; set counter to 1; go to WAIT.
- WAIT state. Acts only when CE=1:
  - If INP_VALID contains the missing bit: capture the missing operand only (MODE/CMD/CIN on that cycle are ignored); go to ISSUE.
  - Otherwise, if counter==TIMEOUT-1: ERR=1 for the next cycle; go to IDLE.
  - Otherwise, counter increments.
  - Net timing: the second operand is accepted up to TIMEOUT-1 cycles after the first. ERR is high exactly TIMEOUT cycles after the first operand.
  - An input arriving in the ERR cycle is treated as a new IDLE command.
  - CE=0 cycles do not count toward the timeout.
- ISSUE state:
  - OUT_* fields are stable and OUT_VALID=1.
  - On OUT_READY=1 (with CE=1): OUT_VALID clears the next cycle and the FSM goes to IDLE.
  - New inputs arriving during ISSUE are dropped.
  - Back-to-back operation: the earliest next capture is the cycle after the handshake.
- CE=0 in any state: all registers hold. An ERR or CMD_ERR pulse already asserted still clears after one cycle.
- Simultaneous events:
  - The timeout compare and a missing-operand arrival in the same cycle: the arrival wins (issue, no ERR).
  - ERR and CMD_ERR are never high together.

Test Plan:
- Reset, then INP_VALID=11, MODE=1, CMD=0, OPA=8'h12, OPB=8'h34 → next cycle OUT_VALID=1, OUT_OPA=12, OUT_OPB=34, OUT_CMD=0. Hold OUT_READY=0 for 3 cycles → fields stable. OUT_READY=1 → OUT_VALID=0 the following cycle.
- MODE=0, CMD=12, INP_VALID=01, OPA=8'hA5 at T0; INP_VALID=10, OPB=8'h0F at T0+15 → issue with OUT_OPA=A5, OUT_OPB=0F, ERR stays 0.
- MODE=1, CMD=8, INP_VALID=10 at T0, then INP_VALID=00 → ERR=1 only at T0+16 and BUSY=0 at T0+16. Repeat with TIMEOUT=4 → ERR at T0+4.
- Same as the previous case but CE=0 for 5 cycles during WAIT → ERR delayed to T0+21.
- MODE=1, CMD=12 with INP_VALID=11 → CMD_ERR pulse of 1 cycle, OUT_VALID=0. MODE=1, CMD=4 with INP_VALID=01, OPA=8'h07 → issue immediately with OUT_OPB=0.
- RST low mid-WAIT and mid-ISSUE → all outputs 0 asynchronously. After RST rises, a fresh INP_VALID=11 issues normally with no stale operand.
